// File: rtl/ibex_qed_pkg.sv
// Shared types, opcode constants and decode helpers for the QED duplicate scheduler.
package ibex_qed_pkg;

    typedef enum logic [1:0] {
        QedIdle = 2'd0,
        QedOrig = 2'd1,
        QedDup  = 2'd2
    } qed_state_e;

    localparam logic [6:0]  OPC_OP         = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM     = 7'b0010011;
    localparam logic [6:0]  OPC_LUI        = 7'b0110111;
    localparam logic [31:0] QED_NOP        = 32'h00000013;
    localparam logic [4:0]  DUP_REG_OFFSET = 5'b10000;

    // Bit 4 of every register field the opcode actually uses (rd, rs1, rs2).
    function automatic logic [31:0] qed_used_msb_mask(input logic [6:0] opcode);
        logic [31:0] mask;
        mask = '0;
        case (opcode)
            OPC_OP:     mask = (32'h1 << 11) | (32'h1 << 19) | (32'h1 << 24);
            OPC_OP_IMM: mask = (32'h1 << 11) | (32'h1 << 19);
            OPC_LUI:    mask = (32'h1 << 11);
            default:    mask = '0;
        endcase
        return mask;
    endfunction

    // Supported = known opcode and every used register field in x0..x15.
    function automatic bit qed_supported(input logic [31:0] instr);
        logic known;
        known = (instr[6:0] == OPC_OP) || (instr[6:0] == OPC_OP_IMM) || (instr[6:0] == OPC_LUI);
        return known && ((instr & qed_used_msb_mask(instr[6:0])) == 32'h0);
    endfunction

    // Move each used nonzero register field into the upper register half; x0 stays x0.
    function automatic logic [31:0] qed_remap(input logic [31:0] instr);
        logic [31:0] mask;
        logic [31:0] res;
        mask = qed_used_msb_mask(instr[6:0]);
        res  = instr;
        if (mask[11] && (instr[11:7]  != 5'd0)) res[11:7]  = instr[11:7]  | DUP_REG_OFFSET;
        if (mask[19] && (instr[19:15] != 5'd0)) res[19:15] = instr[19:15] | DUP_REG_OFFSET;
        if (mask[24] && (instr[24:20] != 5'd0)) res[24:20] = instr[24:20] | DUP_REG_OFFSET;
        return res;
    endfunction

endpackage

// File: rtl/ibex_qed_instr_fifo.sv
// Circular instruction buffer holding original instructions until they are replayed.
module ibex_qed_instr_fifo #(
    parameter int unsigned Depth = 4,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  logic [31:0]    data_i,
    input  logic           pop_i,
    output logic           full_o,
    output logic           empty_o,
    output logic [31:0]    head_o,
    output logic [AddrW:0] count_o
);

    localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(Depth);

    logic [31:0]    mem [Depth];
    logic [AddrW:0] wr_ptr;
    logic [AddrW:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (push_i && !full_o) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i && !empty_o) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    // NOTE: the data array is deliberately not reset; clearing the pointers is enough to discard it.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem[wr_ptr[AddrW-1:0]] <= data_i;
    end

    assign count_o = wr_ptr - rd_ptr;
    assign full_o  = (count_o == FullCnt);
    assign empty_o = (wr_ptr == rd_ptr);
    assign head_o  = mem[rd_ptr[AddrW-1:0]];

endmodule

// File: rtl/ibex_qed_dup_scheduler.sv
// Symbolic-QED scheduler: forwards originals, records them, replays remapped duplicates
// and counts register-file commits of both halves.
module ibex_qed_dup_scheduler
    import ibex_qed_pkg::*;
#(
    parameter int unsigned Depth    = 4,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                qed_en_i,
    input  logic                exec_dup_i,
    input  logic [31:0]         instr_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    output logic [31:0]         qed_instr_o,
    output logic                qed_valid_o,
    input  logic                qed_ready_i,
    output logic                qed_vld_o,
    output logic                qed_is_dup_o,
    input  logic                commit_we_i,
    input  logic [4:0]          commit_waddr_i,
    input  logic                commit_qed_i,
    output logic [CntWidth-1:0] num_orig_o,
    output logic [CntWidth-1:0] num_dup_o,
    output logic                qed_ready_o
);

    localparam int unsigned FifoCntW = $clog2(Depth) + 1;
    localparam logic [FifoCntW-1:0] AlmostFullCnt = FifoCntW'(Depth - 1);
    localparam logic [FifoCntW-1:0] OneCnt        = FifoCntW'(1);

    qed_state_e          state_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic [31:0]         fifo_head;
    logic [FifoCntW-1:0] fifo_count;
    logic                supported;
    logic                push;
    logic                pop;

    assign supported = qed_supported(instr_i);

    // Handshake and instruction mux for bypass, original and duplicate phases.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        qed_instr_o   = instr_i;
        qed_valid_o   = instr_valid_i;
        instr_ready_o = qed_ready_i;
        qed_vld_o     = 1'b0;
        qed_is_dup_o  = 1'b0;
        case (state_q)
            QedOrig: begin
                qed_instr_o   = supported ? instr_i : QED_NOP;
                qed_valid_o   = instr_valid_i & ~fifo_full;
                instr_ready_o = qed_ready_i & ~fifo_full;
                qed_vld_o     = 1'b1;
            end
            QedDup: begin
                qed_instr_o   = qed_remap(fifo_head);
                qed_valid_o   = ~fifo_empty;
                instr_ready_o = 1'b0;
                qed_vld_o     = 1'b1;
                qed_is_dup_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign push = (state_q == QedOrig) & instr_valid_i & instr_ready_o & supported;
    assign pop  = (state_q == QedDup) & qed_valid_o & qed_ready_i;

    ibex_qed_instr_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (instr_i),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    // Phase sequencing: bypass -> originals -> duplicates drained -> originals or bypass.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= QedIdle;
        end else begin
            case (state_q)
                QedIdle: begin
                    if (qed_en_i) state_q <= QedOrig;
                end
                QedOrig: begin
                    if ((push && (fifo_count == AlmostFullCnt)) ||
                        (exec_dup_i && (push || !fifo_empty))) begin
                        state_q <= QedDup;
                    end else if (!qed_en_i && fifo_empty && !push) begin
                        state_q <= QedIdle;
                    end
                end
                QedDup: begin
                    if (pop && (fifo_count == OneCnt)) begin
                        state_q <= qed_en_i ? QedOrig : QedIdle;
                    end
                end
                default: state_q <= QedIdle;
            endcase
        end
    end

    // Commit counters split by destination register half; x0 writes count nowhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_orig_o <= '0;
            num_dup_o  <= '0;
        end else if (commit_we_i && commit_qed_i) begin
            if (commit_waddr_i[4]) begin
                num_dup_o <= num_dup_o + CntWidth'(1);
            end else if (commit_waddr_i != 5'd0) begin
                num_orig_o <= num_orig_o + CntWidth'(1);
            end
        end
    end

    assign qed_ready_o = (num_orig_o == num_dup_o) && (num_orig_o != '0) &&
                         (state_q == QedOrig) && fifo_empty;

endmodule

// File: tb/tb_ibex_qed_dup_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_ibex_qed_dup_scheduler;

    localparam int DEPTH = 4;
    localparam int M_IDLE = 0;
    localparam int M_ORIG = 1;
    localparam int M_DUP  = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        qed_en_i = 1'b0;
    logic        exec_dup_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] qed_instr_o;
    logic        qed_valid_o;
    logic        qed_ready_i = 1'b0;
    logic        qed_vld_o;
    logic        qed_is_dup_o;
    logic        commit_we_i = 1'b0;
    logic [4:0]  commit_waddr_i = '0;
    logic        commit_qed_i = 1'b0;
    logic [15:0] num_orig_o;
    logic [15:0] num_dup_o;
    logic        qed_ready_o;

    ibex_qed_dup_scheduler #(.Depth(DEPTH), .CntWidth(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .qed_en_i       (qed_en_i),
        .exec_dup_i     (exec_dup_i),
        .instr_i        (instr_i),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .qed_instr_o    (qed_instr_o),
        .qed_valid_o    (qed_valid_o),
        .qed_ready_i    (qed_ready_i),
        .qed_vld_o      (qed_vld_o),
        .qed_is_dup_o   (qed_is_dup_o),
        .commit_we_i    (commit_we_i),
        .commit_waddr_i (commit_waddr_i),
        .commit_qed_i   (commit_qed_i),
        .num_orig_o     (num_orig_o),
        .num_dup_o      (num_dup_o),
        .qed_ready_o    (qed_ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        vld;
        logic        dup;
        logic        qrdy;
        logic        chk;
        logic [31:0] instr;
        logic [15:0] norig;
        logic [15:0] ndup;
    } st_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        vld;
        logic        dup;
    } tr_t;

    st_t st_q[$];
    tr_t tr_q[$];
    st_t mon_s;
    tr_t mon_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: phase, pending originals, commit counts.
    int          m_mode = M_IDLE;
    logic [31:0] m_fifo[$];
    int          m_orig = 0;
    int          m_dup  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register fields the instruction uses, by opcode.
    function automatic void ref_uses(input logic [31:0] ins, output bit u_rd, output bit u_rs1,
                                     output bit u_rs2, output bit known);
        u_rd = 0; u_rs1 = 0; u_rs2 = 0; known = 1;
        case (ins[6:0])
            7'b0110011: begin u_rd = 1; u_rs1 = 1; u_rs2 = 1; end
            7'b0010011: begin u_rd = 1; u_rs1 = 1; end
            7'b0110111: u_rd = 1;
            default:    known = 0;
        endcase
    endfunction

    function automatic bit ref_supported(input logic [31:0] ins);
        bit a, b, c, k;
        ref_uses(ins, a, b, c, k);
        if (!k) return 0;
        if (a && ins[11:7]  >= 16) return 0;
        if (b && ins[19:15] >= 16) return 0;
        if (c && ins[24:20] >= 16) return 0;
        return 1;
    endfunction

    // Used fields are below 16 here, so adding 16 to a field is the same as setting its top bit.
    function automatic logic [31:0] ref_remap(input logic [31:0] ins);
        bit a, b, c, k;
        logic [31:0] res;
        ref_uses(ins, a, b, c, k);
        res = ins;
        if (a && ins[11:7]  != 0) res = res + (32'd16 << 7);
        if (b && ins[19:15] != 0) res = res + (32'd16 << 15);
        if (c && ins[24:20] != 0) res = res + (32'd16 << 20);
        return res;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_fifo.delete();
        m_orig = 0;
        m_dup  = 0;
    endtask

    // Hold reset for n cycles; every output is expected low with all inputs low.
    task automatic do_reset(input int n);
        st_t s;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            rst_ni = 0; qed_en_i = 0; exec_dup_i = 0; instr_i = '0; instr_valid_i = 0;
            qed_ready_i = 0; commit_we_i = 0; commit_waddr_i = '0; commit_qed_i = 0;
            model_reset();
            s = '0;
            s.chk = 1;
            st_q.push_back(s);
        end
    endtask

    // Drive one cycle of stimulus and queue the responses the model predicts for it.
    task automatic cycle(input logic en, input logic exec, input logic [31:0] ins, input logic iv,
                         input logic dr, input logic cwe, input logic [4:0] cwa, input logic cq);
        st_t s;
        bit  sup;
        bit  xfer;
        int  sz;
        @(posedge clk_i); #1;
        rst_ni = 1; qed_en_i = en; exec_dup_i = exec; instr_i = ins; instr_valid_i = iv;
        qed_ready_i = dr; commit_we_i = cwe; commit_waddr_i = cwa; commit_qed_i = cq;
        sz  = m_fifo.size();
        sup = ref_supported(ins);
        s = '0;
        s.norig = m_orig[15:0];
        s.ndup  = m_dup[15:0];
        s.qrdy  = (m_orig == m_dup) && (m_orig != 0) && (m_mode == M_ORIG) && (sz == 0);
        s.chk   = 1;
        if (m_mode == M_IDLE) begin
            s.valid = iv; s.ready = dr; s.instr = ins;
        end else if (m_mode == M_ORIG) begin
            s.valid = iv && (sz < DEPTH); s.ready = dr && (sz < DEPTH);
            s.instr = sup ? ins : NOP; s.vld = 1;
        end else begin
            s.valid = (sz > 0); s.ready = 0; s.vld = 1; s.dup = 1;
            s.chk   = (sz > 0);
            s.instr = (sz > 0) ? ref_remap(m_fifo[0]) : 32'h0;
        end
        xfer = s.valid && dr;
        st_q.push_back(s);
        if (xfer) tr_q.push_back('{instr: s.instr, vld: s.vld, dup: s.dup});

        if (m_mode == M_IDLE) begin
            if (en) m_mode = M_ORIG;
        end else if (m_mode == M_ORIG) begin
            if (xfer && sup) m_fifo.push_back(ins);
            if (m_fifo.size() == DEPTH || (exec && m_fifo.size() > 0)) m_mode = M_DUP;
            else if (!en && m_fifo.size() == 0) m_mode = M_IDLE;
        end else if (xfer) begin
            m_fifo.delete(0);
            if (m_fifo.size() == 0) m_mode = en ? M_ORIG : M_IDLE;
        end
        if (cwe && cq && cwa != 0) begin
            if (cwa < 16) m_orig = (m_orig + 1) % 65536;
            else          m_dup  = (m_dup + 1) % 65536;
        end
    endtask

    task automatic idle_cycle(input logic en);
        cycle(en, 0, 32'h0, 0, 1, 0, 5'd0, 0);
    endtask

    task automatic at_negedge();
        @(negedge clk_i); #1;
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        logic [31:0] r;
        logic [4:0] rd, rs1, rs2;
        k   = $urandom_range(0, 9);
        r   = $urandom;
        rd  = 5'($urandom_range(0, (k == 7) ? 31 : 15));
        rs1 = 5'($urandom_range(0, (k == 7) ? 31 : 15));
        rs2 = 5'($urandom_range(0, (k == 7) ? 31 : 15));
        if (k <= 2 || k == 7) return {r[31:25], rs2, rs1, r[14:12], rd, 7'b0110011};
        if (k <= 4)           return {r[31:20], rs1, r[14:12], rd, 7'b0010011};
        if (k <= 6)           return {r[31:12], rd, 7'b0110111};
        return r;
    endfunction

    // Monitor: per-cycle status compare plus transfer-by-transfer scoreboard.
    always @(negedge clk_i) begin
        if (st_q.size() > 0) begin
            mon_s = st_q.pop_front();
            check("qed_valid", {31'b0, qed_valid_o}, {31'b0, mon_s.valid});
            check("instr_ready", {31'b0, instr_ready_o}, {31'b0, mon_s.ready});
            check("qed_vld", {31'b0, qed_vld_o}, {31'b0, mon_s.vld});
            check("qed_is_dup", {31'b0, qed_is_dup_o}, {31'b0, mon_s.dup});
            check("qed_ready", {31'b0, qed_ready_o}, {31'b0, mon_s.qrdy});
            check("num_orig", {16'b0, num_orig_o}, {16'b0, mon_s.norig});
            check("num_dup", {16'b0, num_dup_o}, {16'b0, mon_s.ndup});
            if (mon_s.chk) check("qed_instr", qed_instr_o, mon_s.instr);
        end
        if (qed_valid_o && qed_ready_i && rst_ni) begin
            if (tr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_transfer: got instr %h expected no transfer at %0t", qed_instr_o, $time);
            end else begin
                mon_t = tr_q.pop_front();
                check("xfer_instr", qed_instr_o, mon_t.instr);
                check("xfer_dup", {31'b0, qed_is_dup_o}, {31'b0, mon_t.dup});
            end
        end
    end

    initial begin
        do_reset(2);

        // Bypass.
        cycle(0, 0, 32'h002081B3, 1, 1, 0, 5'd0, 0);
        at_negedge();
        check("bypass_instr", qed_instr_o, 32'h002081B3);
        check("bypass_vld", {31'b0, qed_vld_o}, 32'h0);

        // Remap: two originals, then explicit switch to duplicates.
        idle_cycle(1);
        cycle(1, 0, 32'h002081B3, 1, 1, 0, 5'd0, 0);
        cycle(1, 0, 32'h00500093, 1, 1, 0, 5'd0, 0);
        cycle(1, 1, 32'h0, 0, 1, 0, 5'd0, 0);
        idle_cycle(1);
        at_negedge();
        check("remap_add", qed_instr_o, 32'h012889B3);
        check("remap_is_dup", {31'b0, qed_is_dup_o}, 32'h1);
        idle_cycle(1);
        at_negedge();
        check("remap_addi", qed_instr_o, 32'h00500893);
        idle_cycle(1);
        at_negedge();
        check("back_to_orig", {31'b0, qed_is_dup_o}, 32'h0);

        // Unsupported instructions become NOPs; exec with empty FIFO is ignored.
        cycle(1, 0, 32'h000000EF, 1, 1, 0, 5'd0, 0);
        at_negedge();
        check("nop_jal", qed_instr_o, NOP);
        cycle(1, 0, 32'h00208A33, 1, 1, 0, 5'd0, 0);
        at_negedge();
        check("nop_x20", qed_instr_o, NOP);
        cycle(1, 1, 32'h0, 0, 1, 0, 5'd0, 0);
        idle_cycle(1);
        at_negedge();
        check("exec_ignored", {31'b0, qed_is_dup_o}, 32'h0);

        // Fill the FIFO, stall the duplicate head, then drain.
        cycle(1, 0, 32'h002081B3, 1, 1, 0, 5'd0, 0);
        cycle(1, 0, 32'h00500093, 1, 1, 0, 5'd0, 0);
        cycle(1, 0, 32'h00108113, 1, 1, 0, 5'd0, 0);
        cycle(1, 0, 32'h123452B7, 1, 1, 0, 5'd0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 32'h00308193, 1, 0, 0, 5'd0, 0);
            at_negedge();
            check("stall_head", qed_instr_o, 32'h012889B3);
            check("stall_ready", {31'b0, instr_ready_o}, 32'h0);
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h00308193, 1, 1, 0, 5'd0, 0);

        // Commit counting and check point.
        cycle(1, 0, 32'h0, 0, 1, 1, 5'd3, 1);
        cycle(1, 0, 32'h0, 0, 1, 1, 5'd19, 1);
        idle_cycle(1);
        at_negedge();
        check("cnt_orig", {16'b0, num_orig_o}, 32'd1);
        check("cnt_dup", {16'b0, num_dup_o}, 32'd1);
        check("cnt_qed_ready", {31'b0, qed_ready_o}, 32'h1);
        cycle(1, 0, 32'h0, 0, 1, 1, 5'd0, 1);
        idle_cycle(1);
        at_negedge();
        check("cnt_x0", {16'b0, num_orig_o}, 32'd1);

        // Reset while duplicates are pending.
        cycle(1, 0, 32'h002081B3, 1, 1, 0, 5'd0, 0);
        cycle(1, 0, 32'h00500093, 1, 1, 0, 5'd0, 0);
        cycle(1, 1, 32'h0, 0, 0, 0, 5'd0, 0);
        cycle(1, 0, 32'h0, 0, 0, 0, 5'd0, 0);
        do_reset(1);
        cycle(0, 0, 32'h00A00093, 1, 0, 0, 5'd0, 0);
        at_negedge();
        check("rst_valid_follows", {31'b0, qed_valid_o}, 32'h1);
        check("rst_vld", {31'b0, qed_vld_o}, 32'h0);
        check("rst_cnt", {16'b0, num_orig_o}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1);
            cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0), rand_instr(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
        end

        idle_cycle(1);
        at_negedge();
        check("status_queue_drained", st_q.size(), 32'd0);
        check("transfer_queue_drained", tr_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_qed_dup_scheduler.md
Name: ibex_qed_dup_scheduler

Overview:
- Symbolic-QED instruction scheduler between the instruction source and ID for formal runs.
- Forwards "original" instructions, restricted to x0..x15, and records them in a FIFO.
- Then replays them as "duplicate" instructions with register fields remapped to x16..x31.
- Counts original and duplicate register-file commits and raises qed_ready_o when the two halves are ready for consistency checking.

Parameters:
- Depth, 4, FIFO entries (power of 2, 2..16).
- CntWidth, 16, commit counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- qed_en_i  in  1  enable QED scheduling; 0 = transparent bypass
- exec_dup_i  in  1  request switch to duplicate phase
- instr_i  in  32  upstream instruction
- instr_valid_i  in  1  upstream valid
- instr_ready_o  out  1  upstream ready
- qed_instr_o  out  32  instruction to ID
- qed_valid_o  out  1  downstream valid
- qed_ready_i  in  1  downstream ready
- qed_vld_o  out  1  current transfer belongs to a QED sequence
- qed_is_dup_o  out  1  current transfer is a duplicate
- commit_we_i  in  1  register-file write enable at writeback
- commit_waddr_i  in  5  register-file write address
- commit_qed_i  in  1  committing instruction carried qed_vld
- num_orig_o  out  CntWidth  original commit count
- num_dup_o  out  CntWidth  duplicate commit count
- qed_ready_o  out  1  consistency check point reached

Behaviour:
- Reset: state IDLE, FIFO empty, counters 0. All outputs 0 except qed_instr_o, which equals instr_i (bypass).
- A transfer on either side occurs when valid and ready are both high in the same cycle.
- IDLE:
  - qed_instr_o=instr_i, qed_valid_o=instr_valid_i, instr_ready_o=qed_ready_i, qed_vld_o=0.
  - Go to ORIG when qed_en_i=1, sampled at the clock edge.
- ORIG:
  - Supported: OP (0110011; rd, rs1, rs2), OP-IMM (0010011; rd, rs1), LUI (0110111; rd), with every used register field <16.
  - A supported instruction is forwarded unchanged and pushed into the FIFO on transfer.
  - Anything else is forwarded as NOP 0x00000013 and not pushed.
  - instr_ready_o = qed_ready_i & !full. qed_valid_o = instr_valid_i & !full. qed_vld_o=1, qed_is_dup_o=0.
  - Go to DUP if a push makes the FIFO full, or if exec_dup_i=1 while the FIFO is non-empty (after any same-cycle push).
  - exec_dup_i with an empty FIFO is ignored.
  - Go to IDLE if qed_en_i=0 with an empty FIFO.
- DUP:
  - instr_ready_o=0. qed_valid_o=!empty.
  - qed_instr_o = FIFO head with each used nonzero register field OR'd with 5'b10000; x0 stays x0, all other bits unchanged.
  - qed_vld_o=1, qed_is_dup_o=1. Pop on transfer.
  - After the last pop, go to ORIG, or to IDLE if qed_en_i=0.
  - qed_en_i and exec_dup_i are ignored until drained.
- FIFO: circular buffer, pointers wrap modulo Depth. No push in DUP, no pop in ORIG, so push and pop are never simultaneous.
- Commit counting (any state):
  - orig increments when commit_we_i & commit_qed_i & waddr in 1..15.
  - dup increments when commit_we_i & commit_qed_i & waddr >= 16.
  - Write to x0 counts nowhere.
  - Counters wrap modulo 2^CntWidth.
- qed_ready_o: combinational, = (num_orig_o==num_dup_o) & (num_orig_o!=0) & state==ORIG & FIFO empty.
- Reset asserted mid-sequence: FIFO contents discarded, counters cleared, state IDLE, all the same cycle.
- Downstream stall (qed_ready_i=0): qed_instr_o and qed_valid_o stay stable until transfer.

Decomposition:
- Package ibex_qed_pkg holds:
  - state enum qed_state_e {QedIdle, QedOrig, QedDup}
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI
  - QED_NOP = 32'h00000013
  - DUP_REG_OFFSET = 5'b10000
  - function qed_remap(instr) -> instr
  - function qed_supported(instr) -> bit
- Sub-module ibex_qed_instr_fifo: parameterised Depth; push, pop, full, empty, head data; async active-low reset.
- Top level holds the FSM, remap mux and counters.

Test Plan:
- Bypass: qed_en_i=0, instr 0x002081B3 -> qed_instr_o=0x002081B3, qed_vld_o=0, FIFO stays empty.
- Remap: ORIG accepts add x3,x1,x2 (0x002081B3) and addi x1,x0,5 (0x00500093), then exec_dup_i=1. Expected:
  - DUP emits 0x012889B3 then 0x00500893 with qed_is_dup_o=1.
  - Returns to ORIG after the second pop.
- Unsupported: jal 0x000000EF, and add x20,x1,x2, in ORIG -> output 0x00000013, no push; exec_dup_i then ignored (FIFO empty).
- Full and stall: Depth=4, 4 supported pushes -> auto DUP, instr_ready_o=0. Hold qed_ready_i=0 for 3 cycles -> head instruction stable; then drains 4 in order.
- Counters: commits to waddr 3 then 19 with commit_qed_i=1 -> num_orig_o=1, num_dup_o=1, qed_ready_o=1 in ORIG with FIFO empty. Commit to x0 -> no change.
- Reset mid-DUP with 2 entries pending -> next cycle state IDLE, counters 0, qed_valid_o follows instr_valid_i.
